// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-level UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 87;  // 10 MHz clock, 115200 baud

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte strobe in, serial line and status out, between the unpacker and the UART transmitter.
interface uart_tx_serializer_if;

    logic [uart_pkg::UART_DATA_BITS-1:0] data_in;
    logic                                data_valid;
    logic                                tx;
    logic                                busy;
    logic                                done;
    logic                                overflow;

    modport master (
        output data_in, data_valid,
        input  tx, busy, done, overflow
    );

    modport slave (
        input  data_in, data_valid,
        output tx, busy, done, overflow
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, flags the last cycle and reloads.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end_o = en_i && (cnt_q == LAST);

    // NOTE: always_comb assigns every output on every path (default first), so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking ones would race other flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a one-byte holding register, fed by the 64-bit-to-byte unpacker.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  bus
);

    localparam int                   BIT_CNT_W = $clog2(UART_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(UART_DATA_BITS - 1);

    uart_tx_state_t              state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]   hold_q, hold_d;
    logic                        hold_full_q, hold_full_d;
    logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                        overflow_q, overflow_d;
    logic                        busy_q, tx_q, tx_d;
    logic                        bit_end, stop_end, launch_hold, direct_load;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q != IDLE),
        .bit_end_o (bit_end)
    );

    assign stop_end    = (state_q == STOP) && bit_end;
    // The holding register drains when a frame ends, or immediately if it is full while idle.
    assign launch_hold = hold_full_q && ((state_q == IDLE) || stop_end);
    assign direct_load = (state_q == IDLE) && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (hold_full_q || bus.data_valid) begin
                    state_d = START;
                    shift_d = hold_full_q ? hold_q : bus.data_in;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = hold_full_q ? START : IDLE;
                    if (hold_full_q) begin
                        shift_d = hold_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch_hold) begin
            hold_full_d = 1'b0;
        end

        if (bus.data_valid && !direct_load) begin
            if (!hold_full_q || launch_hold) begin
                hold_d      = bus.data_in;
                hold_full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            overflow_q  <= overflow_d;
            busy_q      <= (state_d != IDLE) || hold_full_d;
            tx_q        <= tx_d;
        end
    end

    // NOTE: the byte registers carry no reset; they are only read once a valid flag or state says so.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        hold_q  <= hold_d;
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = stop_end;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: per-cycle comparison against a frame-timing model plus scenario checks.
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    typedef logic [7:0] byte_q_t [$];
    typedef bit         bit_q_t  [$];

    logic clk;
    logic rst;
    uart_tx_serializer_if bus();

    uart_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model: which byte is on the line, when its frame began, and the holding slot.
    bit         m_active;
    int         m_fs;
    logic [7:0] m_byte;
    bit         m_hold_full;
    logic [7:0] m_hold;
    bit         m_ovf;

    task automatic model_reset();
        m_active    = 1'b0;
        m_fs        = 0;
        m_byte      = 8'h00;
        m_hold_full = 1'b0;
        m_hold      = 8'h00;
        m_ovf       = 1'b0;
    endtask

    // Expected {tx, busy, done, overflow} for the current cycle.
    function automatic logic [3:0] model_out();
        logic t, d;
        int   k;
        t = 1'b1;
        d = 1'b0;
        if (m_active) begin
            k = (cyc - m_fs) / CPB;
            if (k == 0) t = 1'b0;
            else if (k <= 8) t = m_byte[k-1];
            d = (cyc == m_fs + FRAME - 1);
        end
        return {t, m_active | m_hold_full, d, m_ovf};
    endfunction

    task automatic model_update(input bit dv, input logic [7:0] din, input bit r);
        bit eof;
        eof = m_active && (cyc == m_fs + FRAME - 1);
        if (r) begin
            model_reset();
        end else if (!m_active || eof) begin
            if (m_hold_full) begin
                m_active    = 1'b1;
                m_fs        = cyc + 1;
                m_byte      = m_hold;
                m_hold_full = dv;
                if (dv) m_hold = din;
            end else if (!m_active && dv) begin
                m_active = 1'b1;
                m_fs     = cyc + 1;
                m_byte   = din;
            end else begin
                m_active = 1'b0;
                if (dv) begin
                    m_hold      = din;
                    m_hold_full = 1'b1;
                end
            end
        end else if (dv) begin
            if (!m_hold_full) begin
                m_hold      = din;
                m_hold_full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Sample this cycle's outputs, then drive this cycle's inputs and advance the model.
    task automatic step(input bit dv, input logic [7:0] din, input bit r,
                        output logic [3:0] obs, output logic [3:0] exp);
        @(negedge clk);
        obs = {bus.tx, bus.busy, bus.done, bus.overflow};
        exp = model_out();
        rst            = r;
        bus.data_valid = dv;
        bus.data_in    = dv ? din : 8'($urandom);
        model_update(dv, din, r);
        cyc++;
    endtask

    // Plain UART receiver over per-cycle tx samples.
    function automatic byte_q_t decode(input bit_q_t s);
        byte_q_t    q;
        logic [7:0] b;
        int         i;
        i = 0;
        while (i + 9 * CPB + CPB / 2 < s.size()) begin
            if (s[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = s[i + CPB * (k + 1) + CPB / 2];
                q.push_back(b);
                i += FRAME;
            end else begin
                i++;
            end
        end
        return q;
    endfunction

    task automatic test_reset();
        logic [3:0] obs, exp;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, obs, exp);
            tests_run++;
            if (obs !== 4'b1000) begin
                tests_failed++;
                $display("FAIL reset_state cyc=%0d tx/busy/done/ovf got %b want 1000", cyc, obs);
            end
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_model cyc=%0d got %b want %b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] obs, exp;
        int c0, s, ndone, dcyc, busy_after;
        bit_q_t smp;
        byte_q_t got;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        c0 = cyc; ndone = 0; dcyc = -1; busy_after = -1;
        for (int i = 0; i < 48; i++) begin
            s = cyc;
            step(i == 0, 8'hA5, 1'b0, obs, exp);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL single cyc=%0d got %b want %b", s, obs, exp);
            end
            smp.push_back(obs[3]);
            if (obs[1]) begin ndone++; dcyc = s; end
            if (dcyc >= 0 && s == dcyc + 1) busy_after = int'(obs[2]);
        end
        got = decode(smp);
        tests_run += 4;
        if (ndone != 1) begin tests_failed++; $display("FAIL single_done_count got %0d want 1", ndone); end
        if (dcyc - c0 != 40) begin tests_failed++; $display("FAIL single_done_latency got %0d want 40", dcyc - c0); end
        if (busy_after != 0) begin tests_failed++; $display("FAIL single_busy_fall got %0d want 0", busy_after); end
        if (got.size() != 1 || got[0] !== 8'hA5) begin
            tests_failed++; $display("FAIL single_decode got %p want A5", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs, exp;
        int c0, s, ndone, d1, d2, tx_after;
        bit busy_dropped;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        c0 = cyc; ndone = 0; d1 = -1; d2 = -1; tx_after = -1; busy_dropped = 1'b0;
        for (int i = 0; i < 90; i++) begin
            s = cyc;
            step(i == 0 || i == 5, (i == 0) ? 8'h00 : 8'hFF, 1'b0, obs, exp);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL b2b cyc=%0d got %b want %b", s, obs, exp);
            end
            if (s > c0 && ndone < 2 && !obs[2]) busy_dropped = 1'b1;
            if (d1 >= 0 && s == d1 + 1) tx_after = int'(obs[3]);
            if (obs[1]) begin
                ndone++;
                if (d1 < 0) d1 = s; else d2 = s;
            end
        end
        tests_run += 5;
        if (ndone != 2) begin tests_failed++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        if (d2 - c0 != 80) begin tests_failed++; $display("FAIL b2b_total got %0d want 80", d2 - c0); end
        if (tx_after != 0) begin tests_failed++; $display("FAIL b2b_second_start got %0d want 0", tx_after); end
        if (busy_dropped) begin tests_failed++; $display("FAIL b2b_busy got 0 want 1"); end
        if (obs[0] !== 1'b0) begin tests_failed++; $display("FAIL b2b_overflow got %b want 0", obs[0]); end
    endtask

    task automatic test_overflow();
        logic [3:0] obs, exp;
        logic [7:0] b;
        int c0, s, ndone, first_ovf;
        bit_q_t smp;
        byte_q_t got, want;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        c0 = cyc; ndone = 0; first_ovf = -1;
        for (int i = 0; i < 90; i++) begin
            s = cyc;
            b = (i == 0) ? 8'h11 : (i == 4) ? 8'h22 : 8'h33;
            step(i == 0 || i == 4 || i == 8, b, 1'b0, obs, exp);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL overflow cyc=%0d got %b want %b", s, obs, exp);
            end
            smp.push_back(obs[3]);
            if (obs[1]) ndone++;
            if (obs[0] && first_ovf < 0) first_ovf = s - c0;
        end
        got = decode(smp);
        want = '{8'h11, 8'h22};
        tests_run += 4;
        if (obs[0] !== 1'b1) begin tests_failed++; $display("FAIL overflow_sticky got %b want 1", obs[0]); end
        if (first_ovf != 9) begin tests_failed++; $display("FAIL overflow_set_cycle got %0d want 9", first_ovf); end
        if (ndone != 2) begin tests_failed++; $display("FAIL overflow_done_count got %0d want 2", ndone); end
        if (got != want) begin tests_failed++; $display("FAIL overflow_decode got %p want %p", got, want); end
    endtask

    task automatic test_boundary();
        logic [3:0] obs, exp;
        logic [7:0] b;
        int s, ndone;
        int dc [3];
        bit_q_t smp;
        byte_q_t got, want;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        ndone = 0;
        for (int i = 0; i < 130; i++) begin
            s = cyc;
            b = (i == 0) ? 8'h01 : (i == 2) ? 8'h02 : 8'h5A;
            step(i == 0 || i == 2 || i == 40, b, 1'b0, obs, exp);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL boundary cyc=%0d got %b want %b", s, obs, exp);
            end
            smp.push_back(obs[3]);
            if (obs[1]) begin
                if (ndone < 3) dc[ndone] = s;
                ndone++;
            end
        end
        got = decode(smp);
        want = '{8'h01, 8'h02, 8'h5A};
        tests_run += 4;
        if (ndone != 3) begin tests_failed++; $display("FAIL boundary_done_count got %0d want 3", ndone); end
        else if (dc[1] - dc[0] != 40 || dc[2] - dc[1] != 40) begin
            tests_failed++; $display("FAIL boundary_contiguous got gaps %0d,%0d want 40,40", dc[1] - dc[0], dc[2] - dc[1]);
        end
        if (obs[0] !== 1'b0) begin tests_failed++; $display("FAIL boundary_overflow got %b want 0", obs[0]); end
        if (got != want) begin tests_failed++; $display("FAIL boundary_decode got %p want %p", got, want); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        logic [7:0] b;
        int s, ndone;
        bit_q_t smp;
        byte_q_t got;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            s = cyc;
            b = (i == 0) ? 8'h96 : 8'hC3;
            step(i == 0 || i == 20, b, i == 18, obs, exp);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL reset_mid cyc=%0d got %b want %b", s, obs, exp);
            end
            if (i == 19) begin
                tests_run++;
                if (obs !== 4'b1000) begin
                    tests_failed++;
                    $display("FAIL reset_mid_abort got %b want 1000", obs);
                end
            end
            if (i >= 19) begin
                smp.push_back(obs[3]);
                if (obs[1]) ndone++;
            end
        end
        got = decode(smp);
        tests_run += 2;
        if (ndone != 1) begin tests_failed++; $display("FAIL reset_mid_done_count got %0d want 1", ndone); end
        if (got.size() != 1 || got[0] !== 8'hC3) begin
            tests_failed++; $display("FAIL reset_mid_decode got %p want C3", got);
        end
    endtask

    task automatic test_integration();
        logic [3:0] obs, exp;
        logic [63:0] dat;
        bit dv, send;
        int s, idx, ndone, last_d, max_gap;
        bit_q_t smp;
        byte_q_t got, want;
        dat = 64'h0807060504030201;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        idx = 0; send = 1'b0; ndone = 0; last_d = -1; max_gap = 0;
        for (int i = 0; i < 360; i++) begin
            s = cyc;
            dv = (idx < 8) && (i == 0 || send);
            step(dv, dat[8*idx +: 8], 1'b0, obs, exp);
            if (dv) idx++;
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL integration cyc=%0d got %b want %b", s, obs, exp);
            end
            smp.push_back(obs[3]);
            send = obs[1];
            if (obs[1]) begin
                ndone++;
                if (last_d >= 0 && s - last_d > max_gap) max_gap = s - last_d;
                last_d = s;
            end
        end
        got = decode(smp);
        want = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        tests_run += 3;
        if (ndone != 8) begin tests_failed++; $display("FAIL integration_done_count got %0d want 8", ndone); end
        if (max_gap < 40 || max_gap > 41) begin
            tests_failed++; $display("FAIL integration_gap got %0d want 40..41", max_gap);
        end
        if (got != want) begin tests_failed++; $display("FAIL integration_decode got %p want %p", got, want); end
    endtask

    task automatic test_random();
        logic [3:0] obs, exp;
        int s;
        step(1'b0, 8'h00, 1'b1, obs, exp);
        for (int i = 0; i < 1500; i++) begin
            s = cyc;
            step($urandom_range(0, 14) == 0, 8'($urandom), $urandom_range(0, 499) == 0, obs, exp);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL random cyc=%0d got %b want %b", s, obs, exp);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_boundary();
        test_reset_mid();
        test_integration();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Byte-level UART transmitter that sits directly downstream of the 64-bit-to-byte unpacker.
- Consumes its byte strobe (data_in/data_valid) and drives the 8N1 serial line: start bit, 8 data bits LSB first, stop bit.
- Returns a one-cycle done pulse, wired to the unpacker's next_uart, to request the next byte.
- A one-byte holding register lets a byte arrive while a frame is in flight without being lost.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per serial bit (10 MHz / 115200). Legal range is >= 2; an elaboration assertion enforces it.
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter (derived, not overridden).

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  reset: synchronous and active-high (one clock; the polarity and synchronicity are fixed).
- data_in  input  8  byte to transmit, sampled when data_valid=1.
- data_valid  input  1  one-cycle byte strobe (unpacker flat_out).
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is being sent or the holding register is full.
- done  output  1  one-cycle pulse on the last cycle of each stop bit.
- overflow  output  1  sticky flag: a byte was dropped.

Behaviour:
- Reset, sampled at a clk edge with rst=1:
  - Outputs: tx=1, busy=0, done=0, overflow=0.
  - Internal: state=IDLE, holding register empty, counters cleared.
  - Reset mid-frame aborts the frame and tx returns high the next cycle.
- States:
  - IDLE: tx=1.
  - START: tx=0, lasts CLKS_PER_BIT cycles.
  - DATA: tx=shift[0], each bit lasts CLKS_PER_BIT cycles. The register shifts right and bit_cnt increments on the last cycle of each bit. After bit 7, go to STOP.
  - STOP: tx=1, lasts CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads to 0 on each bit boundary, and is held at 0 in IDLE.
- Latency: data_valid in IDLE loads the shift register directly. The next cycle is the first cycle of START (tx=0). A frame is exactly 10*CLKS_PER_BIT cycles.
- done: asserted for exactly one cycle, on the final cycle of STOP (baud_cnt=CLKS_PER_BIT-1).
- At the end of STOP:
  - If the holding register is full, its byte moves into the shift register, the register is marked empty, and START begins next cycle. There is no idle gap.
  - Otherwise go to IDLE.
- Accept rules, applied when data_valid=1:
  - IDLE: byte goes to the shift register.
  - Not IDLE, holding register empty: byte goes to the holding register.
  - Not IDLE, holding register full, on the end-of-STOP cycle: the holding register is vacated this cycle, so the new byte is written into it (accepted).
  - Not IDLE, holding register full, any other cycle: byte dropped, overflow set.
- overflow: sticky; cleared only by rst.
- busy = (state != IDLE) | hold_full, registered so it is valid the cycle after the accept.
- data_in is ignored whenever data_valid=0.

Decomposition:
- Shared package uart_pkg:
  - typedef enum logic [1:0] uart_tx_state_t {IDLE, START, DATA, STOP}.
  - Constant UART_DATA_BITS = 8.
  - Default CLKS_PER_BIT localparam.
- One natural sub-module: uart_baud_tick.
  - Parameterised counter with an enable input.
  - Asserts bit_end when the count reaches CLKS_PER_BIT-1 and reloads to 0.
- FSM, shift register and holding register stay in the top module.

Test Plan:
- Single byte, CLKS_PER_BIT=4: one strobe with data_in=8'hA5 in IDLE.
  - tx, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - done pulses once, 40 cycles after the accept cycle.
  - busy falls 1 cycle after done.
- Back-to-back: strobe 8'h00, then strobe 8'hFF 5 cycles later.
  - Second byte held; busy stays 1.
  - Second start bit begins the cycle after the first done. Total 80 cycles; 2 done pulses; overflow=0.
- Overflow: strobe 8'h11, 8'h22, 8'h33 within 10 cycles.
  - 8'h33 is dropped and overflow=1 from then on.
  - Only 8'h11 and 8'h22 appear on tx.
- Boundary: with the holding register full, strobe 8'h5A exactly on the done cycle.
  - Accepted; overflow=0.
  - Three frames transmitted contiguously.
- Reset mid-frame: rst=1 during DATA bit 3.
  - The next cycle shows tx=1, busy=0, done=0, overflow=0.
  - A following strobe of 8'hC3 produces a clean full frame.
- Integration with the unpacker: input_dato=64'h0807060504030201, start pulse, done wired to next_uart.
  - Bytes 01..08 appear on tx LSB-first with no idle gaps beyond one cycle.
  - Exactly 8 done pulses.
